fetch_queue: RTL and testbench

- Instruction fetch front end feeding the decode-stage registers (instruction, PC, PC+4) of the segmented RISC-V core.
- Replaces the combinational instruction-memory read with a request/response port to a latency-tolerant instruction memory, backed by a small prefetch FIFO.
- Honours the core's hazard stall (hold decode) and branch/jump redirect (flush, inject NOP bubble, refetch).

---
 rtl/fetch_queue.sv | 160 ++++++++++++++++
 tb/tb_fetch_queue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: request/response imem port, prefetch FIFO, decode registers.
// Define FETCH_PERF_CNT_EN to add the perf_bubbles / perf_redirects counters.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_de,
    output logic [31:0] pc_de,
    output logic [31:0] pcinc_de,
    output logic        inst_valid_de
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_redirects
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;

    logic [CW:0]   credit_used;
    logic          accept;
    logic          keep;
    logic          fifo_empty;
    logic          pop;
    logic          bypass;
    logic          push;

    // Credits cover both buffered words and words still in flight, so the FIFO never overflows.
    always_comb begin
        credit_used    = {1'b0, count} + {1'b0, outstanding};
        imem_req_valid = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
        imem_req_addr  = fetch_pc;
        accept         = imem_req_valid && imem_req_ready;
        keep           = imem_resp_valid && (drop == '0);
        fifo_empty     = (count == '0);
        pop            = !redirect && !stall && !fifo_empty;
        bypass         = !redirect && !stall && fifo_empty && keep;
        push           = !redirect && keep && !bypass;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= imem_resp_data;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

    // On redirect every request still in flight is stale, so drop inherits the whole outstanding count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
            if (redirect) begin
                drop     <= outstanding - CW'(imem_resp_valid);
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_resp_valid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (keep) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_de       <= NOP_INST;
            pc_de         <= '0;
            pcinc_de      <= '0;
            inst_valid_de <= 1'b0;
        end else if (redirect) begin
            inst_de       <= NOP_INST;
            inst_valid_de <= 1'b0;
        end else if (stall) begin
            inst_de       <= inst_de;
        end else if (pop) begin
            inst_de       <= fifo_inst[rd_ptr];
            pc_de         <= fifo_pc[rd_ptr];
            pcinc_de      <= fifo_pc[rd_ptr] + 32'd4;
            inst_valid_de <= 1'b1;
        end else if (bypass) begin
            inst_de       <= imem_resp_data;
            pc_de         <= resp_pc;
            pcinc_de      <= resp_pc + 32'd4;
            inst_valid_de <= 1'b1;
        end else begin
            inst_de       <= NOP_INST;
            inst_valid_de <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // A bubble is any non-stalled edge that leaves decode without a real instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bubbles   <= '0;
            perf_redirects <= '0;
        end else begin
            if (!stall && !(pop || bypass)) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
            if (redirect) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

    resp_has_request: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (outstanding != '0));

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push |-> ((count != CW'(DEPTH)) || pop));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: variable-latency memory model plus an in-order scoreboard
// of expected decode instructions, with hold/bubble/redirect checks on every cycle.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst_de;
    logic [31:0] pc_de;
    logic [31:0] pcinc_de;
    logic        inst_valid_de;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubbles;
    logic [31:0] perf_redirects;
`endif

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .inst_de(inst_de),
        .pc_de(pc_de),
        .pcinc_de(pcinc_de),
        .inst_valid_de(inst_valid_de)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_bubbles(perf_bubbles),
        .perf_redirects(perf_redirects)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    mem_req_t    mem_q[$];
    exp_t        sb_q[$];
    int          cyc;
    int          lat;
    int          vectors;
    int          miscompares;
    int          valid_seen;
    logic [31:0] exp_fetch_pc;
    logic [31:0] last_inst;
    logic [31:0] last_pc;
    logic [31:0] last_pcinc;
    logic        last_valid;
    logic [31:0] exp_bubbles;
    logic [31:0] exp_redirects;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_inst"}, inst_de, NOP_INST);
        checkOutput({tag, "_valid"}, 32'(inst_valid_de), 32'd0);
        checkOutput({tag, "_pc"}, pc_de, 32'd0);
        checkOutput({tag, "_pcinc"}, pcinc_de, 32'd0);
        checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput({tag, "_perf_bubbles"}, perf_bubbles, 32'd0);
        checkOutput({tag, "_perf_redirects"}, perf_redirects, 32'd0);
`endif
    endtask

    task automatic clearModel();
        mem_q.delete();
        sb_q.delete();
        exp_fetch_pc  = RESET_PC;
        last_inst     = NOP_INST;
        last_pc       = 32'd0;
        last_pcinc    = 32'd0;
        last_valid    = 1'b0;
        exp_bubbles   = 32'd0;
        exp_redirects = 32'd0;
    endtask

    // One clock cycle: entered just after a falling edge, returns at the next falling edge.
    task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc);
        exp_t e;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q[0].addr | 32'h13;
            void'(mem_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'd0;
        end
        #1;
        if (rd) begin
            checkOutput("req_during_redirect", 32'(imem_req_valid), 32'd0);
            sb_q.delete();
            exp_fetch_pc = rpc;
            exp_redirects++;
        end else if (imem_req_valid && imem_req_ready) begin
            checkOutput("req_addr", imem_req_addr, exp_fetch_pc);
            mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
            sb_q.push_back('{inst: exp_fetch_pc | 32'h13, pc: exp_fetch_pc});
            exp_fetch_pc += 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rd) begin
            checkOutput("redirect_inst", inst_de, NOP_INST);
            checkOutput("redirect_valid", 32'(inst_valid_de), 32'd0);
            checkOutput("redirect_pc_hold", pc_de, last_pc);
            checkOutput("redirect_pcinc_hold", pcinc_de, last_pcinc);
        end else if (st) begin
            checkOutput("stall_inst_hold", inst_de, last_inst);
            checkOutput("stall_pc_hold", pc_de, last_pc);
            checkOutput("stall_pcinc_hold", pcinc_de, last_pcinc);
            checkOutput("stall_valid_hold", 32'(inst_valid_de), 32'(last_valid));
        end else if (inst_valid_de) begin
            checkOutput("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("dec_inst", inst_de, e.inst);
                checkOutput("dec_pc", pc_de, e.pc);
                checkOutput("dec_pcinc", pcinc_de, e.pc + 32'd4);
            end
            valid_seen++;
        end else begin
            checkOutput("bubble_inst", inst_de, NOP_INST);
            checkOutput("bubble_pc_hold", pc_de, last_pc);
        end
        if (!st && !inst_valid_de) begin
            exp_bubbles++;
        end
        checkOutput("outstanding_bound", 32'(mem_q.size() <= DEPTH), 32'd1);
        last_inst  = inst_de;
        last_pc    = pc_de;
        last_pcinc = pcinc_de;
        last_valid = inst_valid_de;
        @(negedge clk);
    endtask

    task automatic waitValid(input string tag, input logic [31:0] target);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            if (inst_valid_de) begin
                found = 1'b1;
            end
        end
        checkOutput({tag, "_found"}, 32'(found), 32'd1);
        if (found) begin
            checkOutput({tag, "_pc"}, pc_de, target);
            checkOutput({tag, "_pcinc"}, pcinc_de, target + 32'd4);
        end
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        valid_seen      = 0;
        cyc             = 0;
        lat             = 1;
        rst             = 1'b1;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'd0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        clearModel();
        #1;
        checkReset("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] 1-cycle memory streaming");
        applyStimulus(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            checkOutput("stream_valid", 32'(inst_valid_de), 32'd1);
        end

        $display("[TB] 3-cycle memory throughput");
        lat = 3;
        repeat (8) applyStimulus(1'b0, 1'b0, 32'd0);
        valid_seen = 0;
        repeat (8) applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("lat3_throughput", 32'(valid_seen), 32'd8);

        $display("[TB] stall with FIFO filling");
        lat = 1;
        repeat (4) applyStimulus(1'b0, 1'b0, 32'd0);
        repeat (5) applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("stall_req_blocked", 32'(imem_req_valid), 32'd0);
        repeat (10) applyStimulus(1'b0, 1'b0, 32'd0);

        $display("[TB] reset pulsed mid-stream");
        rst             = 1'b1;
        imem_resp_valid = 1'b0;
        clearModel();
        #2;
        checkReset("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("first_req_addr", imem_req_addr, RESET_PC);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'd0);

        $display("[TB] redirect with two requests outstanding");
        imem_req_ready = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b0, 32'd0);
        lat            = 3;
        imem_req_ready = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("two_in_flight", 32'(mem_q.size()), 32'd2);
        applyStimulus(1'b0, 1'b1, 32'h100);
        waitValid("redir100", 32'h100);

        $display("[TB] redirect while stale responses are still being dropped");
        repeat (4) applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h180);
        applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h1C0);
        waitValid("redir1c0", 32'h1C0);

        $display("[TB] redirect and stall together");
        lat = 1;
        repeat (4) applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h200);
        waitValid("redir200", 32'h200);

        $display("[TB] random request backpressure");
        for (int i = 0; i < 12; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, 1'b0, 32'd0);
        end
        imem_req_ready = 1'b1;
        repeat (6) applyStimulus(1'b0, 1'b0, 32'd0);

`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_bubbles", perf_bubbles, exp_bubbles);
        checkOutput("perf_redirects", perf_redirects, exp_redirects);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
